// File: rtl/stack_controller.sv
// ============================================================================
// Module  : stack_controller
// Brief   : Push/pop/peek sequencer for the 8Queen backtracking stack datapath.
//           Optional peek support: define STACK_CTRL_PEEK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_controller #(
  parameter int DEPTH = 8,
  parameter int SIZE  = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_req,
  input  logic            pop_req,
  input  logic            peek_req,
  input  logic            msb,
  input  logic            zero,
  input  logic [SIZE-1:0] stack_top,
  output logic            push,
  output logic            pop,
  output logic            ack,
  output logic            err,
  output logic [SIZE-1:0] pop_data,
  output logic            overflow,
  output logic            underflow,
  output logic            busy
);

  // The datapath full flag is its counter MSB, which only works for 2**n entries.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("stack_controller: DEPTH must be a power of 2");
  end

`ifdef STACK_CTRL_PEEK_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PUSH = 3'd1,
    S_POP  = 3'd2,
    S_ACK  = 3'd3,
    S_PEEK = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PUSH = 3'd1,
    S_POP  = 3'd2,
    S_ACK  = 3'd3
  } state_t;

  logic peek_unused;
  assign peek_unused = peek_req;
`endif

  state_t          state_q;
  logic            push_q;
  logic            pop_q;
  logic            ack_q;
  logic            err_q;
  logic [SIZE-1:0] pop_data_q;
  logic            overflow_q;
  logic            underflow_q;
  logic            busy_q;

  // All outputs are registered; strobes are asserted on entry to their state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      pop_data_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_req) begin
            busy_q <= 1'b1;
            if (!zero) begin
              state_q <= S_POP;
              pop_q   <= 1'b1;
            end else begin
              state_q     <= S_ACK;
              ack_q       <= 1'b1;
              err_q       <= 1'b1;
              underflow_q <= 1'b1;
            end
          end else if (push_req) begin
            busy_q <= 1'b1;
            if (!msb) begin
              state_q <= S_PUSH;
              push_q  <= 1'b1;
            end else begin
              state_q    <= S_ACK;
              ack_q      <= 1'b1;
              err_q      <= 1'b1;
              overflow_q <= 1'b1;
            end
          end
`ifdef STACK_CTRL_PEEK_EN
          else if (peek_req) begin
            busy_q <= 1'b1;
            if (!zero) begin
              state_q <= S_PEEK;
            end else begin
              state_q     <= S_ACK;
              ack_q       <= 1'b1;
              err_q       <= 1'b1;
              underflow_q <= 1'b1;
            end
          end
`endif
        end
        S_PUSH: begin
          push_q  <= 1'b0;
          ack_q   <= 1'b1;
          err_q   <= 1'b0;
          state_q <= S_ACK;
        end
        S_POP: begin
          // Datapath decrements on this same edge, so stack_top is still the old top.
          pop_q      <= 1'b0;
          pop_data_q <= stack_top;
          ack_q      <= 1'b1;
          err_q      <= 1'b0;
          state_q    <= S_ACK;
        end
`ifdef STACK_CTRL_PEEK_EN
        S_PEEK: begin
          pop_data_q <= stack_top;
          ack_q      <= 1'b1;
          err_q      <= 1'b0;
          state_q    <= S_ACK;
        end
`endif
        S_ACK: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          push_q  <= 1'b0;
          pop_q   <= 1'b0;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign push      = push_q;
  assign pop       = pop_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign pop_data  = pop_data_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_stack_controller.sv
// ============================================================================
// Module  : tb_stack_controller
// Brief   : Self-checking bench for stack_controller with a behavioural stack datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_controller;

  localparam int DEPTH = 8;
  localparam int SIZE  = 6;
  localparam int TMO   = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            push_req = 1'b0;
  logic            pop_req = 1'b0;
  logic            peek_req = 1'b0;
  logic            msb;
  logic            zero;
  logic [SIZE-1:0] stack_top;
  logic            push;
  logic            pop;
  logic            ack;
  logic            err;
  logic [SIZE-1:0] pop_data;
  logic            overflow;
  logic            underflow;
  logic            busy;
  logic [SIZE-1:0] bus_in = '0;

  always #5 clk = ~clk;

  stack_controller #(.DEPTH(DEPTH), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req),
    .peek_req(peek_req), .msb(msb), .zero(zero), .stack_top(stack_top),
    .push(push), .pop(pop), .ack(ack), .err(err), .pop_data(pop_data),
    .overflow(overflow), .underflow(underflow), .busy(busy)
  );

  // Behavioural datapath: up/down counter plus register file.
  logic [3:0]      cnt;
  logic [SIZE-1:0] mem [DEPTH];
  logic [2:0]      top_idx;

  assign top_idx   = cnt[2:0] - 3'd1;
  assign stack_top = mem[top_idx];
  assign msb       = cnt[3];
  assign zero      = (cnt == 4'd0);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (push) begin
      mem[cnt[2:0]] <= bus_in;
      cnt           <= cnt + 4'd1;
    end else if (pop) begin
      cnt <= cnt - 4'd1;
    end
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one request until ack (or timeout); reports latency and strobes seen.
  task automatic do_op(input logic pu, input logic po, input logic pe, input logic [SIZE-1:0] d,
                       output int lat, output logic e, output logic sp, output logic so,
                       output logic bz);
    @(negedge clk);
    push_req = pu; pop_req = po; peek_req = pe; bus_in = d;
    lat = 0; sp = 1'b0; so = 1'b0; e = 1'b0; bz = 1'b0;
    while (!ack && lat < TMO) begin
      @(negedge clk);
      lat++;
      if (push) sp = 1'b1;
      if (pop)  so = 1'b1;
    end
    e  = err;
    bz = busy;
    push_req = 1'b0; pop_req = 1'b0; peek_req = 1'b0;
  endtask

  typedef struct {
    logic            pu;
    logic            po;
    logic [SIZE-1:0] d;
    logic            e;
    int              lat;
    logic [SIZE-1:0] pd;
    logic            ov;
    logic            un;
    logic            sp;
    logic            so;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int lat;
    logic e, sp, so, bz;
    int acks;

    // push 2A, pop it, pop empty, push 1..8, push full, pop 8..1, pop empty
    tbl[0]  = '{1'b1, 1'b0, 6'h2A, 1'b0, 2, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 6'h00, 1'b0, 2, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 6'h00, 1'b1, 1, 6'h2A, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[3+i] = '{1'b1, 1'b0, 6'(i+1), 1'b0, 2, 6'h2A, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 6'h09, 1'b1, 1, 6'h2A, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int j = 0; j < 8; j++)
      tbl[12+j] = '{1'b0, 1'b1, 6'h00, 1'b0, 2, 6'(8-j), 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 6'h00, 1'b1, 1, 6'h01, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_push", 32'(push), 32'd0);
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    check("rst_data", 32'(pop_data), 32'd0);
    reset = 1'b1;

    for (int k = 0; k < 21; k++) begin
      do_op(tbl[k].pu, tbl[k].po, 1'b0, tbl[k].d, lat, e, sp, so, bz);
      check($sformatf("v%0d_lat", k), 32'(lat), 32'(tbl[k].lat));
      check($sformatf("v%0d_err", k), 32'(e), 32'(tbl[k].e));
      check($sformatf("v%0d_busy", k), 32'(bz), 32'd1);
      check($sformatf("v%0d_push", k), 32'(sp), 32'(tbl[k].sp));
      check($sformatf("v%0d_pop", k), 32'(so), 32'(tbl[k].so));
      @(negedge clk);
      check($sformatf("v%0d_data", k), 32'(pop_data), 32'(tbl[k].pd));
      check($sformatf("v%0d_ovf", k), 32'(overflow), 32'(tbl[k].ov));
      check($sformatf("v%0d_unf", k), 32'(underflow), 32'(tbl[k].un));
      check($sformatf("v%0d_idle", k), 32'(busy), 32'd0);
    end

    // Simultaneous push and pop with 3 entries: pop wins
    for (int i = 0; i < 3; i++)
      do_op(1'b1, 1'b0, 1'b0, 6'(6'h10 + i), lat, e, sp, so, bz);
    do_op(1'b1, 1'b1, 1'b0, 6'h33, lat, e, sp, so, bz);
    check("both_pop", 32'(so), 32'd1);
    check("both_nopush", 32'(sp), 32'd0);
    @(negedge clk);
    check("both_data", 32'(pop_data), 32'h12);
    do_op(1'b1, 1'b0, 1'b0, 6'h33, lat, e, sp, so, bz);
    check("both_push2", 32'(sp), 32'd1);
    do_op(1'b0, 1'b1, 1'b0, 6'h00, lat, e, sp, so, bz);
    @(negedge clk);
    check("both_data2", 32'(pop_data), 32'h33);

    // Reset asserted during the PUSH cycle
    @(negedge clk);
    push_req = 1'b1; bus_in = 6'h3C;
    @(posedge clk);
    #1;
    check("rstmid_push_hi", 32'(push), 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid_push_lo", 32'(push), 32'd0);
    check("rstmid_ack", 32'(ack), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    push_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("rstmid_noack", 32'(acks), 32'd0);
    check("rstmid_zero", 32'(zero), 32'd1);
    check("rstmid_ovf", 32'(overflow), 32'd0);
    check("rstmid_unf", 32'(underflow), 32'd0);

    // Peek
    do_op(1'b1, 1'b0, 1'b0, 6'h15, lat, e, sp, so, bz);
`ifdef STACK_CTRL_PEEK_EN
    do_op(1'b0, 1'b0, 1'b1, 6'h00, lat, e, sp, so, bz);
    check("peek_lat", 32'(lat), 32'd2);
    check("peek_err", 32'(e), 32'd0);
    check("peek_nopop", 32'(so), 32'd0);
    @(negedge clk);
    check("peek_data", 32'(pop_data), 32'h15);
    do_op(1'b0, 1'b1, 1'b0, 6'h00, lat, e, sp, so, bz);
    check("peek_pop", 32'(so), 32'd1);
    @(negedge clk);
    check("peek_popdata", 32'(pop_data), 32'h15);
`else
    @(negedge clk);
    peek_req = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack || busy || pop) acks++;
    end
    peek_req = 1'b0;
    check("peek_ignored", 32'(acks), 32'd0);
    check("peek_data", 32'(pop_data), 32'h00);
    check("peek_unf", 32'(underflow), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
